// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and constants for the RegisterFile access controller.
package regfile_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD,
    IOWR,
    IORD
  } state_t;

  localparam logic [4:0] IO_REG_ADDR = 5'd31;

  // One bit per requester; used both for eligible requests and one-hot grants.
  typedef struct packed {
    logic iord;
    logic iowr;
    logic rd;
    logic wb;
  } grant_t;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Requester-side handshake and read-response bundle of regfile_access_ctrl.
interface regfile_access_ctrl_if;
  logic        wb_req;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ack;
  logic        rd_req;
  logic [4:0]  rd_rs1;
  logic [4:0]  rd_rs2;
  logic        rd_ack;
  logic        io_wr_req;
  logic [31:0] io_wr_data;
  logic        io_wr_ack;
  logic        io_rd_req;
  logic        io_rd_ack;
  logic        rsp_valid;
  logic        rsp_io;
  logic [31:0] rsp_rs1;
  logic [31:0] rsp_rs2;

  modport master (
    output wb_req, wb_addr, wb_data, rd_req, rd_rs1, rd_rs2,
           io_wr_req, io_wr_data, io_rd_req,
    input  wb_ack, rd_ack, io_wr_ack, io_rd_ack,
           rsp_valid, rsp_io, rsp_rs1, rsp_rs2
  );

  modport slave (
    input  wb_req, wb_addr, wb_data, rd_req, rd_rs1, rd_rs2,
           io_wr_req, io_wr_data, io_rd_req,
    output wb_ack, rd_ack, io_wr_ack, io_rd_ack,
           rsp_valid, rsp_io, rsp_rs1, rsp_rs2
  );
endinterface

// File: rtl/regfile_access_ctrl_prio_arb.sv
// Fixed-priority picker: starved IO write, write-back, read, IO write, IO read.
module rfc_prio_arb
  import regfile_ctrl_pkg::*;
(
  input  grant_t req,
  input  logic   starved,
  output grant_t gnt
);

  always_comb begin
    gnt = '0;
    if (req.iowr && starved) gnt.iowr = 1'b1;
    else if (req.wb)         gnt.wb   = 1'b1;
    else if (req.rd)         gnt.rd   = 1'b1;
    else if (req.iowr)       gnt.iowr = 1'b1;
    else if (req.iord)       gnt.iord = 1'b1;
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Arbiter/sequencer for the RegisterFile strobe interface.
// Optional r0-hardwired-zero behaviour: define RFC_ZERO_REG_EN.
module regfile_access_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  regfile_access_ctrl_if.slave       bus,
  output logic                       we,
  output logic                       io_we,
  output logic                       RF_trigger,
  output logic                       RF_from_IO,
  output logic [4:0]                 rs1_addr,
  output logic [4:0]                 rs2_addr,
  output logic [4:0]                 rd_addr,
  output logic [31:0]                rd_data,
  output logic [31:0]                data_io,
  input  logic [31:0]                rs1_data,
  input  logic [31:0]                rs2_data
);

  state_t             state, state_d;
  grant_t             elig, gnt;
  logic [CNT_W-1:0]   starve_cnt;
  logic               starved;
  logic               wb_en;
  logic [31:0]        rs1_cap, rs2_cap;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

`ifdef RFC_ZERO_REG_EN
  assign wb_en   = (bus.wb_addr != '0);
  assign rs1_cap = (state == RD && rs1_addr == '0) ? '0 : rs1_data;
  assign rs2_cap = (state == RD && rs2_addr == '0) ? '0 : rs2_data;
`else
  assign wb_en   = 1'b1;
  assign rs1_cap = rs1_data;
  assign rs2_cap = rs2_data;
`endif

  // A requester being acked this cycle is excluded so it cannot be granted twice.
  always_comb begin
    elig.wb   = bus.wb_req    && !bus.wb_ack;
    elig.rd   = bus.rd_req    && !bus.rd_ack;
    elig.iowr = bus.io_wr_req && !bus.io_wr_ack;
    elig.iord = bus.io_rd_req && !bus.io_rd_ack;
  end

  rfc_prio_arb u_arb (
    .req     (elig),
    .starved (starved),
    .gnt     (gnt)
  );

  always_comb begin
    state_d = IDLE;
    if (gnt.wb)        state_d = WB;
    else if (gnt.rd)   state_d = RD;
    else if (gnt.iowr) state_d = IOWR;
    else if (gnt.iord) state_d = IORD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Strobes and acks are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we            <= 1'b0;
      io_we         <= 1'b0;
      RF_trigger    <= 1'b0;
      RF_from_IO    <= 1'b0;
      bus.wb_ack    <= 1'b0;
      bus.rd_ack    <= 1'b0;
      bus.io_wr_ack <= 1'b0;
      bus.io_rd_ack <= 1'b0;
    end else begin
      we            <= (state_d == WB) && wb_en;
      io_we         <= (state_d == IOWR);
      RF_trigger    <= (state_d == RD);
      RF_from_IO    <= (state_d == IORD);
      bus.wb_ack    <= (state_d == WB);
      bus.rd_ack    <= (state_d == RD);
      bus.io_wr_ack <= (state_d == IOWR);
      bus.io_rd_ack <= (state_d == IORD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr  <= '0;
      rd_data  <= '0;
      rs1_addr <= '0;
      rs2_addr <= '0;
      data_io  <= '0;
    end else begin
      if (gnt.wb) begin
        rd_addr <= bus.wb_addr;
        rd_data <= bus.wb_data;
      end
      if (gnt.rd) begin
        rs1_addr <= bus.rd_rs1;
        rs2_addr <= bus.rd_rs2;
      end
      if (gnt.iord) rs1_addr <= IO_REG_ADDR;
      if (gnt.iowr) data_io  <= bus.io_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_io    <= 1'b0;
      bus.rsp_rs1   <= '0;
      bus.rsp_rs2   <= '0;
    end else begin
      bus.rsp_valid <= (state == RD) || (state == IORD);
      bus.rsp_io    <= (state == IORD);
      if ((state == RD) || (state == IORD)) begin
        bus.rsp_rs1 <= rs1_cap;
        bus.rsp_rs2 <= rs2_cap;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 starve_cnt <= '0;
    else if (!bus.io_wr_req || bus.io_wr_ack) starve_cnt <= '0;
    else if (!starved)                       starve_cnt <= starve_cnt + 1'b1;
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed, table-driven bench for regfile_access_ctrl with a RegisterFile model.
module tb_regfile_access_ctrl;

`ifdef RFC_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we, io_we, RF_trigger, RF_from_IO;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rd_data, data_io, rs1_data, rs2_data;
  logic [3:0]  strb;
  logic [31:0] regs [32];

  int n_chk = 0;
  int n_err = 0;

  regfile_access_ctrl_if bus ();

  regfile_access_ctrl #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .we         (we),
    .io_we      (io_we),
    .RF_trigger (RF_trigger),
    .RF_from_IO (RF_from_IO),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .data_io    (data_io),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data)
  );

  always #5 clk = ~clk;

  // RegisterFile model: synchronous write, combinational read.
  always @(posedge clk or posedge rst) begin
    if (rst && $time == 0) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (!rst) begin
      if (we)    regs[rd_addr] <= rd_data;
      if (io_we) regs[31]      <= data_io;
    end
  end
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  assign strb     = {we, RF_trigger, io_we, RF_from_IO};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // op: 0 WB(a,d), 1 RD(a,b), 2 IOWR(d), 3 IORD
  typedef struct {
    logic [1:0]  op;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] d;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ewe;
  } vec_t;

  vec_t vecs [12];

  task automatic clear_reqs();
    bus.wb_req = 1'b0; bus.rd_req = 1'b0; bus.io_wr_req = 1'b0; bus.io_rd_req = 1'b0;
  endtask

  task automatic do_vec(input vec_t v, input int idx);
    logic [3:0] es;
    logic       ack;
    @(negedge clk);
    case (v.op)
      2'd0: begin bus.wb_req = 1'b1; bus.wb_addr = v.a; bus.wb_data = v.d; end
      2'd1: begin bus.rd_req = 1'b1; bus.rd_rs1 = v.a; bus.rd_rs2 = v.b; end
      2'd2: begin bus.io_wr_req = 1'b1; bus.io_wr_data = v.d; end
      default: bus.io_rd_req = 1'b1;
    endcase
    case (v.op)
      2'd0:    es = {v.ewe, 3'b000};
      2'd1:    es = 4'b0100;
      2'd2:    es = 4'b0010;
      default: es = 4'b0001;
    endcase
    @(posedge clk); #1;
    case (v.op)
      2'd0:    ack = bus.wb_ack;
      2'd1:    ack = bus.rd_ack;
      2'd2:    ack = bus.io_wr_ack;
      default: ack = bus.io_rd_ack;
    endcase
    chk($sformatf("v%0d ack", idx), 32'(ack), 32'd1);
    chk($sformatf("v%0d strobe", idx), 32'(strb), 32'(es));
    case (v.op)
      2'd0: begin
        chk($sformatf("v%0d rd_addr", idx), 32'(rd_addr), 32'(v.a));
        chk($sformatf("v%0d rd_data", idx), rd_data, v.d);
      end
      2'd1: begin
        chk($sformatf("v%0d rs1_addr", idx), 32'(rs1_addr), 32'(v.a));
        chk($sformatf("v%0d rs2_addr", idx), 32'(rs2_addr), 32'(v.b));
      end
      2'd2: chk($sformatf("v%0d data_io", idx), data_io, v.d);
      default: ;
    endcase
    @(negedge clk);
    clear_reqs();
    @(posedge clk); #1;
    chk($sformatf("v%0d idle strobe", idx), 32'(strb), 32'd0);
    chk($sformatf("v%0d rsp_valid", idx), 32'(bus.rsp_valid), 32'(v.op == 2'd1 || v.op == 2'd3));
    if (v.op == 2'd1 || v.op == 2'd3) begin
      chk($sformatf("v%0d rsp_io", idx), 32'(bus.rsp_io), 32'(v.op == 2'd3));
      chk($sformatf("v%0d rsp_rs1", idx), bus.rsp_rs1, v.e1);
      if (v.op == 2'd1) chk($sformatf("v%0d rsp_rs2", idx), bus.rsp_rs2, v.e2);
    end
  endtask

  initial begin
    int   first_ack;
    logic we_after;
    logic seen_rsp;
    vec_t v;

    clear_reqs();
    bus.wb_addr = '0; bus.wb_data = '0; bus.rd_rs1 = '0; bus.rd_rs2 = '0; bus.io_wr_data = '0;

    vecs[0]  = '{2'd0, 5'd1,  5'd0, 32'hAAAABBBB, 32'h0, 32'h0, 1'b1};
    vecs[1]  = '{2'd0, 5'd2,  5'd0, 32'h12345678, 32'h0, 32'h0, 1'b1};
    vecs[2]  = '{2'd1, 5'd1,  5'd2, 32'h0, 32'hAAAABBBB, 32'h12345678, 1'b0};
    vecs[3]  = '{2'd2, 5'd0,  5'd0, 32'hA1B2C3D4, 32'h0, 32'h0, 1'b0};
    vecs[4]  = '{2'd3, 5'd0,  5'd0, 32'h0, 32'hA1B2C3D4, 32'h0, 1'b0};
    vecs[5]  = '{2'd0, 5'd0,  5'd0, 32'hCAFEBABE, 32'h0, 32'h0, !ZR};
    vecs[6]  = '{2'd1, 5'd0,  5'd1, 32'h0, ZR ? 32'h0 : 32'hCAFEBABE, 32'hAAAABBBB, 1'b0};
    vecs[7]  = '{2'd0, 5'd31, 5'd0, 32'h00000055, 32'h0, 32'h0, 1'b1};
    vecs[8]  = '{2'd1, 5'd31, 5'd2, 32'h0, 32'h00000055, 32'h12345678, 1'b0};
    vecs[9]  = '{2'd3, 5'd0,  5'd0, 32'h0, 32'h00000055, 32'h0, 1'b0};
    vecs[10] = '{2'd0, 5'd2,  5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1};
    vecs[11] = '{2'd1, 5'd2,  5'd2, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst strobes", 32'(strb), 32'd0);
    chk("rst acks", 32'({bus.wb_ack, bus.rd_ack, bus.io_wr_ack, bus.io_rd_ack}), 32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst rsp_rs1", bus.rsp_rs1, 32'd0);
    chk("rst rd_data", rd_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) do_vec(vecs[i], i);

    // All four requests at once; WB and RD target the same register r5.
    @(negedge clk);
    bus.wb_req = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h0F0F0F0F;
    bus.rd_req = 1'b1; bus.rd_rs1 = 5'd5; bus.rd_rs2 = 5'd1;
    bus.io_wr_req = 1'b1; bus.io_wr_data = 32'h11112222;
    bus.io_rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] es;
      es = 4'b1000 >> k;
      @(posedge clk); #1;
      chk($sformatf("all4 strobe c%0d", k), 32'(strb), 32'(es));
      chk($sformatf("all4 ack c%0d", k),
          32'({bus.wb_ack, bus.rd_ack, bus.io_wr_ack, bus.io_rd_ack}), 32'(es));
      if (k == 2) begin
        chk("all4 rd rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("all4 rd rsp_io", 32'(bus.rsp_io), 32'd0);
        chk("all4 rd rsp_rs1", bus.rsp_rs1, 32'h0F0F0F0F);
        chk("all4 rd rsp_rs2", bus.rsp_rs2, 32'hAAAABBBB);
      end
      @(negedge clk);
      if (bus.wb_ack)    bus.wb_req    = 1'b0;
      if (bus.rd_ack)    bus.rd_req    = 1'b0;
      if (bus.io_wr_ack) bus.io_wr_req = 1'b0;
      if (bus.io_rd_ack) bus.io_rd_req = 1'b0;
    end
    @(posedge clk); #1;
    chk("all4 idle strobe", 32'(strb), 32'd0);
    chk("all4 iord rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("all4 iord rsp_io", 32'(bus.rsp_io), 32'd1);
    chk("all4 iord rsp_rs1", bus.rsp_rs1, 32'h11112222);
    clear_reqs();

    // Starvation: continuous WB and RD traffic hold off the IO write.
    @(negedge clk);
    bus.wb_req = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h00000001;
    bus.rd_req = 1'b1; bus.rd_rs1 = 5'd3; bus.rd_rs2 = 5'd3;
    bus.io_wr_req = 1'b1; bus.io_wr_data = 32'h77778888;
    first_ack = 0;
    we_after  = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("starve onehot c%0d", k), 32'($countones(strb)), 32'd1);
      if (bus.io_wr_ack && first_ack == 0) first_ack = k;
      if (k == 10) we_after = we;
      @(negedge clk);
      if (bus.io_wr_ack) bus.io_wr_req = 1'b0;
    end
    chk("starve io_wr_ack cycle", 32'(first_ack), 32'd9);
    chk("starve wb resumes", 32'(we_after), 32'd1);
    clear_reqs();
    repeat (3) @(posedge clk);

    // Reset in the middle of an RD strobe.
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_rs1 = 5'd1; bus.rd_rs2 = 5'd2;
    @(posedge clk); #1;
    chk("rstmid RF_trigger before", 32'(RF_trigger), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid RF_trigger", 32'(RF_trigger), 32'd0);
    chk("rstmid rd_ack", 32'(bus.rd_ack), 32'd0);
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    rst = 1'b0;
    seen_rsp = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen_rsp = seen_rsp | bus.rsp_valid;
    end
    chk("rstmid no rsp_valid", 32'(seen_rsp), 32'd0);
    v = '{2'd0, 5'd4, 5'd0, 32'h00004444, 32'h0, 32'h0, 1'b1};
    do_vec(v, 99);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Arbiter and sequencer for the `RegisterFile` strobe interface. Four requesters share the register file:
- core write-back,
- core operand read,
- IO write to r31,
- IO read of r31.

The block grants at most one register-file operation per cycle and drives the file's strobes (`we`, `io_we`, `RF_trigger`, `RF_from_IO`) from registers. It captures read data into response registers and prevents IO starvation with a wait counter.

## Interface
- `STARVE_LIMIT`, default 8: consecutive ungranted cycles of `io_wr_req` before it is promoted to top priority.
- `CNT_W`, default 4: width of the starvation counter; must satisfy STARVE_LIMIT < 2^CNT_W.
- `clk` in 1: single clock. One clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `wb_req` in 1, `wb_addr` in 5, `wb_data` in 32, `wb_ack` out 1: write-back request.
- `rd_req` in 1, `rd_rs1` in 5, `rd_rs2` in 5, `rd_ack` out 1: operand read request.
- `io_wr_req` in 1, `io_wr_data` in 32, `io_wr_ack` out 1: IO write to r31.
- `io_rd_req` in 1, `io_rd_ack` out 1: IO read of r31.
- `rsp_valid` out 1, `rsp_io` out 1, `rsp_rs1` out 32, `rsp_rs2` out 32: read response.
- `we`, `io_we`, `RF_trigger`, `RF_from_IO` out 1: strobes to `RegisterFile`.
- `rs1_addr`, `rs2_addr`, `rd_addr` out 5; `rd_data`, `data_io` out 32: address and data to `RegisterFile`.
- `rs1_data`, `rs2_data` in 32: read data from `RegisterFile`.

## Operation
- **Handshake:** a requester holds `req` and its payload stable until `ack`. `ack` is a one-cycle pulse. `req` may drop in the cycle after `ack`, or stay high to issue a new operation.
- **Arbitration:** evaluated every cycle over the live requests. The winner is registered, so the strobe and `ack` are high during the following cycle.
- **Priority, highest first:**
  - `io_wr_req`, but only when starved (counter == STARVE_LIMIT);
  - `wb_req`;
  - `rd_req`;
  - `io_wr_req`;
  - `io_rd_req`.
- **FSM states:** IDLE, WB, RD, IOWR, IORD. The state holds the operation being strobed this cycle.
  - Any state goes to the next winner, or to IDLE if no request is eligible.
  - Back-to-back grants are allowed.
- **Strobe outputs per state:**
  - WB: `we`=1, `rd_addr`/`rd_data` = latched payload.
  - RD: `RF_trigger`=1, `rs1_addr`/`rs2_addr` = latched payload.
  - IOWR: `io_we`=1, `data_io` = latched payload.
  - IORD: `RF_from_IO`=1.
  - Exactly one strobe is high in any cycle. IDLE drives all strobes 0.
- **Re-grant guard:** a request whose `ack` is high this cycle is not eligible for grant in this cycle's arbitration. It can next be granted on the following cycle.
- **Read capture:** at the clock edge ending an RD or IORD cycle, `rs1_data`/`rs2_data` are captured into `rsp_rs1`/`rsp_rs2`. In the next cycle `rsp_valid`=1 for one cycle, and `rsp_io` is 1 if the read was IORD.
  - IORD responses use `rsp_rs1`.
- **Ordering:** a write granted before a read of the same register is visible to that read, because the write completes a full cycle earlier.
- **Starvation counter:**
  - Increments each cycle `io_wr_req` is high and `io_wr_ack` is low.
  - Saturates at STARVE_LIMIT.
  - Clears on `io_wr_ack`, and when `io_wr_req` is low.
- **Reset:**
  - FSM to IDLE.
  - All strobes, acks, `rsp_valid`, `rsp_io` and the counter to 0.
  - Address, data and response registers to 0.
- **Reset mid-operation:** the strobe drops asynchronously and the in-flight `ack`/response is lost. Requesters re-issue after reset.

## Timing
- **Request to ack/strobe:** 1 cycle from `req` sampled high to `ack` and the strobe.
- **Read latency:** 2 cycles from `rd_req` to `rsp_valid`.
- **Throughput:** 1 operation per cycle.
- **Worst-case IO write wait:** STARVE_LIMIT + 1 cycles under continuous write-back/read traffic.
- **Simultaneous `wb_req` and `rd_req` on the same register:** WB is granted first, and the read returns the new value.

## Configuration
- **`RFC_ZERO_REG_EN` defined:** a WB to address 0 is acked normally but `we` stays 0. An RD of address 0 returns 0 in `rsp_rs1`/`rsp_rs2`, regardless of `rs*_data`.
- **Macro undefined:** r0 is an ordinary register. Writes pass through, and reads return the file contents.

## Structure
- **Package `regfile_ctrl_pkg`:**
  - state enum (IDLE, WB, RD, IOWR, IORD);
  - constant IO_REG_ADDR = 5'd31;
  - grant one-hot typedef.
- **Sub-module `rfc_prio_arb`:** a combinational fixed-priority picker with the starved override. It takes the request vector and starved flag and returns a one-hot grant.
- **Top level:** the FSM, payload latches, response capture and counter.

## Test plan
- **Write then read:**
  - WB r1=AAAABBBB, then r2=12345678.
  - Then RD rs1=1, rs2=2.
  - Expect `rsp_valid` 2 cycles after `rd_req`, with `rsp_rs1`=AAAABBBB and `rsp_rs2`=12345678.
- **IO path:**
  - `io_wr_req` with A1B2C3D4: expect `io_we` pulse and `data_io`=A1B2C3D4.
  - Then `io_rd_req`: expect `rsp_io`=1 and `rsp_rs1`=A1B2C3D4.
- **All four requests in one cycle:**
  - Expect the grant order WB, RD, IOWR, IORD on consecutive cycles.
  - Expect exactly one strobe high per cycle.
- **Starvation:**
  - Hold `wb_req` continuously with `io_wr_req` high.
  - Expect `io_wr_ack` no later than cycle STARVE_LIMIT+1 (9), after which WB resumes.
- **r0:**
  - WB r0=CAFEBABE, then RD rs1=0.
  - Expect CAFEBABE without `RFC_ZERO_REG_EN`.
  - Expect 0 and `we` never high with `RFC_ZERO_REG_EN` defined.
- **Reset during an RD strobe:**
  - Expect `RF_trigger`=0 immediately and no `rsp_valid` afterwards.
  - The next request after reset is granted normally.
